// File: rtl/vx_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module   : vx_dispatch_queue
// Brief    : Per-issue-slot operand FIFO that feeds the dispatch unit and
//            tracks how many queued records each warp-in-slot still owns.
//            Optional macro DISPATCH_QUEUE_PERF_EN adds stall/idle counters.
// Revision : 1.0 - initial release
// ============================================================================
module vx_dispatch_queue #(
    parameter int DATAW   = 1024,
    parameter int DEPTH   = 4,
    parameter int NUM_WIS = 4,
    parameter int WIS_OFF = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [DATAW-1:0]   in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [DATAW-1:0]   out_data,
    input  logic               out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic               full,
    output logic               empty,
    output logic [NUM_WIS-1:0] wis_pending
`ifdef DISPATCH_QUEUE_PERF_EN
    ,
    output logic [31:0]        perf_full_stalls,
    output logic [31:0]        perf_empty_cycles
`endif
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_WIS_W = (NUM_WIS > 1) ? $clog2(NUM_WIS) : 1;

    logic [DATAW-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_wcnt [NUM_WIS];

    logic               w_push;
    logic               w_pop;
    logic [c_WIS_W-1:0] w_push_wis;
    logic [c_WIS_W-1:0] w_pop_wis;

    // Status flags come straight from the registered count, so in_ready has
    // no combinational dependence on out_ready.
    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = r_mem[r_rd_ptr];

    assign w_push     = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;
    assign w_push_wis = in_data[WIS_OFF +: c_WIS_W];
    assign w_pop_wis  = out_data[WIS_OFF +: c_WIS_W];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // Per-warp occupancy: a matching push and pop in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_WIS; i++) begin
                r_wcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_WIS; i++) begin
                if (w_push && (w_push_wis == c_WIS_W'(i)) &&
                    !(w_pop && (w_pop_wis == c_WIS_W'(i)))) begin
                    r_wcnt[i] <= r_wcnt[i] + c_CNT_W'(1);
                end else if (w_pop && (w_pop_wis == c_WIS_W'(i)) &&
                             !(w_push && (w_push_wis == c_WIS_W'(i)))) begin
                    r_wcnt[i] <= r_wcnt[i] - c_CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        wis_pending = '0;
        for (int i = 0; i < NUM_WIS; i++) begin
            wis_pending[i] = (r_wcnt[i] != '0);
        end
    end

`ifdef DISPATCH_QUEUE_PERF_EN
    logic [31:0] r_perf_full_stalls;
    logic [31:0] r_perf_empty_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_full_stalls  <= '0;
            r_perf_empty_cycles <= '0;
        end else begin
            if (in_valid && full) begin
                r_perf_full_stalls <= r_perf_full_stalls + 32'd1;
            end
            if (empty && out_ready) begin
                r_perf_empty_cycles <= r_perf_empty_cycles + 32'd1;
            end
        end
    end

    assign perf_full_stalls  = r_perf_full_stalls;
    assign perf_empty_cycles = r_perf_empty_cycles;
`endif

`ifndef SYNTHESIS
    int w_wcnt_sum;

    always_comb begin
        w_wcnt_sum = 0;
        for (int i = 0; i < NUM_WIS; i++) begin
            w_wcnt_sum = w_wcnt_sum + int'(r_wcnt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (in_valid) begin
                assert (int'(w_push_wis) < NUM_WIS)
                    else $error("vx_dispatch_queue: illegal wis %0d", w_push_wis);
            end
            assert (w_wcnt_sum == int'(r_count))
                else $error("vx_dispatch_queue: wcnt sum %0d != count %0d",
                            w_wcnt_sum, r_count);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vx_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_dispatch_queue
// Brief    : Self-checking bench: directed vector table, corner sequences and
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_dispatch_queue;

    localparam int c_DW    = 16;
    localparam int c_DEPTH = 4;
    localparam int c_NW    = 4;
    localparam int c_WOFF  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [c_DW-1:0]   in_data;
    logic              in_ready;
    logic              out_valid;
    logic [c_DW-1:0]   out_data;
    logic              out_ready;
    logic [2:0]        count;
    logic              full;
    logic              empty;
    logic [c_NW-1:0]   wis_pending;
`ifdef DISPATCH_QUEUE_PERF_EN
    logic [31:0]       perf_full_stalls;
    logic [31:0]       perf_empty_cycles;
`endif

    always #5 clk = ~clk;

    vx_dispatch_queue #(
        .DATAW   (c_DW),
        .DEPTH   (c_DEPTH),
        .NUM_WIS (c_NW),
        .WIS_OFF (c_WOFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .wis_pending (wis_pending)
`ifdef DISPATCH_QUEUE_PERF_EN
        ,
        .perf_full_stalls  (perf_full_stalls),
        .perf_empty_cycles (perf_empty_cycles)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: ordered list of records currently held.
    logic [c_DW-1:0] mq[$];

    typedef struct {
        logic            iv;
        logic [c_DW-1:0] din;
        logic            ordy;
        int              exp_cnt;
        logic [c_NW-1:0] exp_pend;
        logic [c_DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [c_NW-1:0] model_pending();
        logic [c_NW-1:0] p = '0;
        foreach (mq[k]) p[mq[k][c_WOFF +: 2]] = 1'b1;
        return p;
    endfunction

    function automatic logic [c_DW-1:0] rec(input int wis, input int payload);
        logic [c_DW-1:0] r = '0;
        r[7:0]          = payload[7:0];
        r[c_WOFF +: 2]  = wis[1:0];
        return r;
    endfunction

    task automatic check_state(input string tag, input int exp_cnt,
                               input logic [c_NW-1:0] exp_pend, input logic [c_DW-1:0] exp_data);
        chk({tag, "_count"}, 32'(count), 32'(exp_cnt));
        chk({tag, "_empty"}, 32'(empty), 32'(exp_cnt == 0));
        chk({tag, "_full"}, 32'(full), 32'(exp_cnt == c_DEPTH));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(exp_cnt != c_DEPTH));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(exp_cnt != 0));
        chk({tag, "_wis_pending"}, 32'(wis_pending), 32'(exp_pend));
        if (exp_cnt != 0) chk({tag, "_out_data"}, 32'(out_data), 32'(exp_data));
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        mq.delete();
    endtask

    // One cycle against the model; entered and left at posedge+1.
    task automatic model_step(input string tag, input logic iv, input logic [c_DW-1:0] d,
                              input logic ordy);
        logic push, pop;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        check_state(tag, mq.size(), model_pending(), (mq.size() > 0) ? mq[0] : '0);
        push = iv && (mq.size() < c_DEPTH);
        pop  = ordy && (mq.size() > 0);
        @(posedge clk); #1;
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(d);
    endtask

    initial begin
        // Directed table: each row's expectations describe the state seen in that cycle.
        vecs.push_back('{0, '0,          0, 0, 4'b0000, '0});
        vecs.push_back('{1, 16'h02A5,    0, 0, 4'b0000, '0});
        vecs.push_back('{0, '0,          1, 1, 4'b0100, 16'h02A5});
        vecs.push_back('{0, '0,          0, 0, 4'b0000, '0});
        vecs.push_back('{1, 16'h0010,    0, 0, 4'b0000, '0});
        vecs.push_back('{1, 16'h0111,    0, 1, 4'b0001, 16'h0010});
        vecs.push_back('{1, 16'h0112,    0, 2, 4'b0011, 16'h0010});
        vecs.push_back('{1, 16'h0313,    0, 3, 4'b0011, 16'h0010});
        vecs.push_back('{1, 16'h0214,    0, 4, 4'b1011, 16'h0010});
        vecs.push_back('{1, 16'h0214,    1, 4, 4'b1011, 16'h0010});
        vecs.push_back('{1, 16'h0214,    0, 3, 4'b1010, 16'h0111});
        vecs.push_back('{0, '0,          1, 4, 4'b1110, 16'h0111});
        vecs.push_back('{0, '0,          1, 3, 4'b1110, 16'h0112});
        vecs.push_back('{0, '0,          1, 2, 4'b1100, 16'h0313});
        vecs.push_back('{0, '0,          1, 1, 4'b0100, 16'h0214});
        vecs.push_back('{1, 16'h0120,    0, 0, 4'b0000, '0});
        vecs.push_back('{1, 16'h0121,    1, 1, 4'b0010, 16'h0120});
        vecs.push_back('{0, '0,          0, 1, 4'b0010, 16'h0121});
        vecs.push_back('{0, '0,          1, 1, 4'b0010, 16'h0121});
        vecs.push_back('{0, '0,          0, 0, 4'b0000, '0});

        do_reset();
        for (int v = 0; v < vecs.size(); v++) begin
            in_valid  = vecs[v].iv;
            in_data   = vecs[v].din;
            out_ready = vecs[v].ordy;
            @(negedge clk);
            check_state($sformatf("vec%0d", v), vecs[v].exp_cnt, vecs[v].exp_pend, vecs[v].exp_data);
            @(posedge clk); #1;
        end

        // Reset with three records queued discards them.
        do_reset();
        for (int i = 0; i < 3; i++) model_step("prefill", 1'b1, rec(i, 8'h40 + i), 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("midreset_pre_count", 32'(count), 32'd3);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = rec(3, 8'h77);
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        mq.delete();
        @(negedge clk);
        check_state("midreset", 0, 4'b0000, '0);
        @(posedge clk); #1;

        // Back-to-back stream: order preserved across pointer wrap, count stays low.
        for (int i = 0; i < 20; i++) begin
            model_step($sformatf("stream%0d", i), 1'b1, rec($urandom_range(0, 3), i), 1'b1);
            chk("stream_count_le1", 32'(count <= 3'd1), 32'd1);
        end
        for (int i = 0; i < 2; i++) model_step("drain", 1'b0, '0, 1'b1);

        // Randomized traffic with varying push/pop bias.
        for (int i = 0; i < 600; i++) begin
            logic [c_DW-1:0] d;
            int bias;
            bias = (i / 100) % 3;
            d    = c_DW'($urandom);
            d[c_WOFF +: 2] = 2'($urandom_range(0, 3));
            model_step("rand",
                       ($urandom_range(0, 3) < (bias == 0 ? 3 : 1)),
                       d,
                       ($urandom_range(0, 3) < (bias == 1 ? 3 : 2)));
        end

`ifdef DISPATCH_QUEUE_PERF_EN
        do_reset();
        for (int i = 0; i < 4; i++) model_step("perf_fill", 1'b1, rec(i, i), 1'b0);
        for (int i = 0; i < 5; i++) model_step("perf_stall", 1'b1, rec(0, 8'hEE), 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("perf_full_stalls", perf_full_stalls, 32'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
